apb_req_master: RTL and testbench

//  - Converts the controller's single-beat valid/ready register requests into APB3 master transfers.
//  - Returns read data as a one-cycle dout_vld strobe.
//  - Sits directly downstream of the I2C command sequencer and upstream of the I2C core's APB slave port.
//  - Exactly one transfer is in flight at a time; requests are registered at acceptance.

---
 rtl/apb_req_master.sv | 159 +++++++++++++++
 tb/tb_apb_req_master.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// Single-outstanding valid/ready to APB3 bridge: accept N, SETUP N+1, ACCESS N+2, result/ready N+3+waits.
// ready is low for the whole transfer; APB_TIMEOUT_EN adds an ACCESS wait-state abort with a timeout strobe.
module apb_req_master #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              ready,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic              dout_vld,
    output logic [DATA_W-1:0] dout,
    output logic              timeout,
    output logic              apb_sel,
    output logic              apb_en,
    output logic              apb_write,
    input  logic              apb_ready,
    output logic [ADDR_W-1:0] apb_addr,
    output logic [DATA_W-1:0] apb_wdata,
    input  logic [DATA_W-1:0] apb_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    logic                r_ready;
    logic                r_dout_vld;
    logic [DATA_W-1:0]   r_dout;
    logic                r_timeout;
    logic                r_apb_sel;
    logic                r_apb_en;
    logic                r_apb_write;
    logic [ADDR_W-1:0]   r_apb_addr;
    logic [DATA_W-1:0]   r_apb_wdata;
    logic                w_accept;

`ifdef APB_TIMEOUT_EN
    logic [15:0]         r_wait_cnt;
    logic                w_expired;

    assign w_expired = (r_wait_cnt == TO_LAST);
`else
    logic                w_unused_cfg;

    assign w_unused_cfg = (^ERR_DATA) ^ (^TO_LAST);
`endif

    assign w_accept = valid & r_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_dout_vld  <= 1'b0;
            r_dout      <= '0;
            r_timeout   <= 1'b0;
            r_apb_sel   <= 1'b0;
            r_apb_en    <= 1'b0;
            r_apb_write <= 1'b0;
            r_apb_addr  <= '0;
            r_apb_wdata <= '0;
`ifdef APB_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            r_dout_vld <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // ready comes up one cycle after reset release, then stays up while idle
                    if (w_accept) begin
                        r_ready     <= 1'b0;
                        r_apb_sel   <= 1'b1;
                        r_apb_write <= write;
                        r_apb_addr  <= addr;
                        r_apb_wdata <= din;
                        r_state     <= S_SETUP;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_apb_en <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state  <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (apb_ready) begin
                        r_apb_sel <= 1'b0;
                        r_apb_en  <= 1'b0;
                        r_ready   <= 1'b1;
                        if (!r_apb_write) begin
                            r_dout     <= apb_rdata;
                            r_dout_vld <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    // Abort reports through timeout only; dout_vld stays low
                    else if (w_expired) begin
                        r_apb_sel <= 1'b0;
                        r_apb_en  <= 1'b0;
                        r_ready   <= 1'b1;
                        r_timeout <= 1'b1;
                        if (!r_apb_write) begin
                            r_dout <= ERR_DATA;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    r_apb_sel <= 1'b0;
                    r_apb_en  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign dout_vld  = r_dout_vld;
    assign dout      = r_dout;
    assign apb_sel   = r_apb_sel;
    assign apb_en    = r_apb_en;
    assign apb_write = r_apb_write;
    assign apb_addr  = r_apb_addr;
    assign apb_wdata = r_apb_wdata;
`ifdef APB_TIMEOUT_EN
    assign timeout   = r_timeout;
`else
    assign timeout   = 1'b0;
`endif

`ifndef SYNTHESIS
    a_no_vld_with_to: assert property (@(posedge clk) disable iff (!rst)
        !(dout_vld && timeout));
    a_en_needs_sel: assert property (@(posedge clk) disable iff (!rst)
        apb_en |-> apb_sel);
    a_ctrl_stable: assert property (@(posedge clk) disable iff (!rst)
        (apb_sel && $past(apb_sel)) |-> ($stable(apb_write) && $stable(apb_addr) && $stable(apb_wdata)));
`endif

endmodule

// File: tb/tb_apb_req_master.sv
// Randomized transaction bench for apb_req_master against a cycle-timeline reference of each APB transfer.
module tb_apb_req_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic          ready;
    logic          write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic          dout_vld;
    logic [DW-1:0] dout;
    logic          timeout;
    logic          apb_sel;
    logic          apb_en;
    logic          apb_write;
    logic          apb_ready = 1'b0;
    logic [AW-1:0] apb_addr;
    logic [DW-1:0] apb_wdata;
    logic [DW-1:0] apb_rdata = '0;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] m_dout = '0;

    apb_req_master #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready), .write(write),
        .addr(addr), .din(din), .dout_vld(dout_vld), .dout(dout), .timeout(timeout),
        .apb_sel(apb_sel), .apb_en(apb_en), .apb_write(apb_write), .apb_ready(apb_ready),
        .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_rdata(apb_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got=running exp=done)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request: accept, SETUP, ACCESS cycles (waits wait states), then the completion cycle.
    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input logic [DW-1:0] rd, input bit b2b);
        int  n;
        int  naccess;
        bit  abort;
        valid     = 1'b1;
        write     = wr;
        addr      = a;
        din       = d;
        apb_ready = 1'($urandom);
        n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
        chk("accept_ready", 32'(ready), 32'd1);
        if (b2b) chk("b2b_gap", 32'(n), 32'd0);
        step();
        valid     = 1'b0;
        write     = 1'($urandom);
        addr      = $urandom;
        din       = $urandom;
        chk("setup_sel", 32'(apb_sel), 32'd1);
        chk("setup_en", 32'(apb_en), 32'd0);
        chk("setup_ready", 32'(ready), 32'd0);
        chk("setup_write", 32'(apb_write), 32'(wr));
        chk("setup_addr", apb_addr, a);
        chk("setup_wdata", apb_wdata, d);
        chk("setup_vld", 32'(dout_vld), 32'd0);
        apb_ready = 1'($urandom);
        apb_rdata = $urandom;
`ifdef APB_TIMEOUT_EN
        abort   = (waits > TO - 1);
        naccess = abort ? TO : waits + 1;
`else
        abort   = 1'b0;
        naccess = waits + 1;
`endif
        for (int i = 0; i < naccess; i++) begin
            step();
            chk("acc_sel", 32'(apb_sel), 32'd1);
            chk("acc_en", 32'(apb_en), 32'd1);
            chk("acc_ready", 32'(ready), 32'd0);
            chk("acc_write", 32'(apb_write), 32'(wr));
            chk("acc_addr", apb_addr, a);
            chk("acc_wdata", apb_wdata, d);
            chk("acc_vld", 32'(dout_vld), 32'd0);
            chk("acc_to", 32'(timeout), 32'd0);
            chk("acc_dout_hold", dout, m_dout);
            apb_ready = (i == waits);
            apb_rdata = (i == waits) ? rd : $urandom;
        end
        step();
        if (!wr) m_dout = abort ? 32'hDEAD_BEEF : rd;
        chk("done_sel", 32'(apb_sel), 32'd0);
        chk("done_en", 32'(apb_en), 32'd0);
        chk("done_ready", 32'(ready), 32'd1);
        chk("done_vld", 32'(dout_vld), 32'(!wr && !abort));
        chk("done_to", 32'(timeout), 32'(abort));
        chk("done_dout", dout, m_dout);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            apb_ready = 1'($urandom);
            step();
            chk("idle_sel", 32'(apb_sel), 32'd0);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_vld", 32'(dout_vld), 32'd0);
        end
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_sel", 32'(apb_sel), 32'd0);
        chk("rst_en", 32'(apb_en), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_vld", 32'(dout_vld), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        valid = 1'b1;
        step();
        step();
        chk("rst_hold_ready", 32'(ready), 32'd0);
        chk("rst_hold_sel", 32'(apb_sel), 32'd0);
        valid = 1'b0;
        rst = 1'b1;
        step();
        chk("post_rst_ready", 32'(ready), 32'd1);

        do_req(1'b1, 32'h10, 32'hC0, 0, 32'h0, 1'b1);
        do_req(1'b0, 32'h0C, 32'h0, 3, 32'h5A, 1'b1);
        for (int k = 0; k < 3; k++)
            do_req(1'($urandom), $urandom, $urandom, 0, $urandom, 1'b1);
        idle_cycles(2);

        for (int k = 0; k < 40; k++) begin
            int w;
`ifdef APB_TIMEOUT_EN
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 4));
`else
            w = int'($urandom_range(0, 5));
`endif
            do_req(1'($urandom), $urandom, $urandom, w, $urandom, 1'b1);
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

`ifdef APB_TIMEOUT_EN
        do_req(1'b0, 32'h20, 32'h0, 100, 32'h1234, 1'b1);
        do_req(1'b0, 32'h24, 32'h0, TO - 1, 32'h77, 1'b1);
        do_req(1'b1, 32'h28, 32'h99, 100, 32'h0, 1'b1);
`else
        do_req(1'b0, 32'h20, 32'h0, 20, 32'h1234, 1'b1);
`endif

        // Reset while in ACCESS with a read pending
        valid     = 1'b1;
        write     = 1'b0;
        addr      = 32'h30;
        apb_ready = 1'b0;
        step();
        valid = 1'b0;
        step();
        step();
        chk("pre_rst_en", 32'(apb_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        m_dout = '0;
        chk("mid_rst_sel", 32'(apb_sel), 32'd0);
        chk("mid_rst_en", 32'(apb_en), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_dout", dout, m_dout);
        apb_ready = 1'b1;
        apb_rdata = 32'hABCD;
        #2 rst = 1'b1;
        step();
        chk("rel_ready", 32'(ready), 32'd1);
        chk("rel_sel", 32'(apb_sel), 32'd0);
        chk("rel_vld", 32'(dout_vld), 32'd0);
        chk("rel_dout", dout, m_dout);
        do_req(1'b0, 32'h34, 32'h0, 1, 32'h600D, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
